// File: rtl/rotor_encrypter.sv
// rotor_encrypter: parametrised rotating-key XOR encrypter/decrypter.
// Words arrive through the reqIn/rdyIn handshake. They are either key chunks
// (programming) or data words (RUN). Processed data words are queued in a
// small output FIFO that drains through the reqOut/rdyOut handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// exactly when the offering side's valid and the accepting side's ready are
// both high. On the input side rdyIn is the source's valid and reqIn is this
// block's ready. On the output side reqOut is this block's valid and rdyOut is
// the sink's ready. reqIn is decoded from registered state only; reqOut is the
// registered FIFO-not-empty flag. Neither depends combinationally on the
// other side's signals.
//
// Optional feature macro: ROTOR_ROLLING_KEY_EN. When it is defined, the working
// key rotates left by one bit after every accepted data word. Without it the
// key stays static between programming sessions.
module rotor_encrypter #(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WORDS  = 1,
    parameter int ROT_WIDTH  = 4,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           dataIn,
    input  logic [ROT_WIDTH-1:0]            rot_offset,
    input  logic                            mode,
    input  logic                            prog,
    input  logic                            rdyIn,
    output logic                            reqIn,
    output logic [DATA_WIDTH-1:0]           dataOut,
    output logic                            reqOut,
    input  logic                            rdyOut,
    output logic [DATA_WIDTH*KEY_WORDS-1:0] key,
    output logic [1:0]                      state
);

    localparam int KEY_WIDTH = DATA_WIDTH * KEY_WORDS;
    localparam int PTR_W     = $clog2(OUT_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int KCNT_W    = $clog2(KEY_WORDS + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(OUT_DEPTH);
    localparam logic [KCNT_W-1:0] KEY_WORDS_C = KCNT_W'(KEY_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROG = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Rotations are taken from a doubled copy of the operand so that any
    // amount in [0, width] works without special-casing zero.
    function automatic logic [DATA_WIDTH-1:0] rotl_data(
        input logic [DATA_WIDTH-1:0] x,
        input logic [31:0]           amt
    );
        return DATA_WIDTH'({x, x} >> (32'(DATA_WIDTH) - amt));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotr_data(
        input logic [DATA_WIDTH-1:0] x,
        input logic [31:0]           amt
    );
        return DATA_WIDTH'({x, x} >> amt);
    endfunction

    // Only the low data-width slice of the rotated key is ever needed.
    function automatic logic [DATA_WIDTH-1:0] key_window(
        input logic [KEY_WIDTH-1:0] k,
        input logic [31:0]          amt
    );
        return DATA_WIDTH'({k, k} >> (32'(KEY_WIDTH) - amt));
    endfunction

    state_t                 state_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [KCNT_W-1:0]      key_cnt;

    logic [DATA_WIDTH-1:0]  fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic [DATA_WIDTH-1:0]  data_out_q;

    logic                   fifo_full;
    logic                   in_xfer;
    logic                   push;
    logic                   pop;

    logic [31:0]            rot_data_amt;
    logic [31:0]            rot_key_amt;
    logic [DATA_WIDTH-1:0]  key_chunk;
    logic [DATA_WIDTH-1:0]  cipher_word;
    logic [KEY_WIDTH-1:0]   key_shifted;

    logic [PTR_W-1:0]       rd_ptr_nxt;
    logic [CNT_W-1:0]       cnt_after_pop;
    logic [CNT_W-1:0]       fifo_cnt_nxt;
    logic [DATA_WIDTH-1:0]  head_nxt;

    assign fifo_full = (fifo_cnt == DEPTH_C);
    assign reqOut    = (fifo_cnt != '0);
    assign dataOut   = data_out_q;
    assign key       = key_q;
    assign state     = state_q;

    // Input readiness comes from registered state and FIFO occupancy only.
    always_comb begin
        reqIn = 1'b0;
        case (state_q)
            ST_PROG: reqIn = 1'b1;
            ST_RUN:  reqIn = !fifo_full;
            default: reqIn = 1'b0;
        endcase
    end

    assign in_xfer = reqIn && rdyIn;
    // A word offered with prog high is a key chunk and never reaches the FIFO.
    assign push    = in_xfer && (state_q == ST_RUN) && !prog;
    assign pop     = reqOut && rdyOut;

    // Cipher datapath for the word currently on dataIn.
    always_comb begin
        rot_data_amt = 32'(rot_offset) % 32'(DATA_WIDTH);
        rot_key_amt  = 32'(rot_offset) % 32'(KEY_WIDTH);
        key_chunk    = key_window(key_q, rot_key_amt);
        if (mode) begin
            cipher_word = rotr_data(dataIn, rot_data_amt) ^ key_chunk;
        end else begin
            cipher_word = rotl_data(dataIn ^ key_chunk, rot_data_amt);
        end
    end

    // New key chunks enter at the LSB end; the oldest chunk falls off the top.
    assign key_shifted = KEY_WIDTH'({key_q, dataIn});

    // Control FSM: owns state, the working key and the key word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            key_cnt <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prog) begin
                        state_q <= ST_PROG;
                        key_cnt <= '0;
                    end
                end
                ST_PROG: begin
                    if (in_xfer) begin
                        key_q <= key_shifted;
                        if (key_cnt != KEY_WORDS_C) begin
                            key_cnt <= key_cnt + 1'b1;
                        end
                    end
                    if (!prog) begin
                        if (key_cnt == KEY_WORDS_C) begin
                            state_q <= ST_RUN;
                        end else begin
                            // Incomplete key: discard it rather than run with
                            // a half-loaded key.
                            state_q <= ST_IDLE;
                            key_q   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    // A word accepted on the edge that raises prog is a key
                    // chunk for a session that has not started yet; it is
                    // dropped and the new session starts with an empty count.
                    if (prog) begin
                        state_q <= ST_PROG;
                        key_cnt <= '0;
                    end else if (push) begin
`ifdef ROTOR_ROLLING_KEY_EN
                        key_q <= KEY_WIDTH'({key_q, key_q} >> (KEY_WIDTH - 1));
`else
                        key_q <= key_q;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Next-cycle FIFO bookkeeping and the word that will sit at the head.
    always_comb begin
        rd_ptr_nxt    = rd_ptr + PTR_W'(pop);
        cnt_after_pop = fifo_cnt - CNT_W'(pop);
        fifo_cnt_nxt  = cnt_after_pop + CNT_W'(push);
        // If nothing older survives this edge, the head is the word being
        // pushed right now (bypass the memory write).
        if (cnt_after_pop == '0) begin
            head_nxt = cipher_word;
        end else begin
            head_nxt = fifo_mem[rd_ptr_nxt];
        end
    end

    // FIFO storage: written only by data words accepted in RUN.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cipher_word;
        end
    end

    // FIFO pointers, occupancy and the registered head word on dataOut.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            data_out_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr   <= rd_ptr_nxt;
            fifo_cnt <= fifo_cnt_nxt;
            // When the FIFO goes empty, dataOut keeps the last popped word.
            if (fifo_cnt_nxt != '0) begin
                data_out_q <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rotor_encrypter.sv
// Testbench for rotor_encrypter (default parameters: 16-bit data, one key
// word, 4-bit rotation, 4-entry output FIFO).
module tb_rotor_encrypter;

  localparam int DW = 16;
  localparam int KW = 1;
  localparam int RW = 4;
  localparam int OD = 4;
  localparam int KB = DW * KW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] dataIn;
  logic [RW-1:0] rot_offset;
  logic          mode;
  logic          prog;
  logic          rdyIn;
  logic          reqIn;
  logic [DW-1:0] dataOut;
  logic          reqOut;
  logic          rdyOut;
  logic [KB-1:0] key;
  logic [1:0]    state;

  always #5 clk = ~clk;

  rotor_encrypter #(
    .DATA_WIDTH (DW),
    .KEY_WORDS  (KW),
    .ROT_WIDTH  (RW),
    .OUT_DEPTH  (OD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .rot_offset (rot_offset),
    .mode       (mode),
    .prog       (prog),
    .rdyIn      (rdyIn),
    .reqIn      (reqIn),
    .dataOut    (dataOut),
    .reqOut     (reqOut),
    .rdyOut     (rdyOut),
    .key        (key),
    .state      (state)
  );

  // ---------------- scoreboard / model ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [KB-1:0] key_m;
  int            key_cnt_m;
  bit            rnd_on;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-permutation rotate: bit i moves to position (i+n) mod w.
  function automatic logic [63:0] rot_left(input logic [63:0] x, input int w, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[(i + n) % w] = x[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] model_cipher(input logic [DW-1:0] d, input int rot, input bit md);
    logic [63:0] kk;
    logic [DW-1:0] k;
    logic [63:0] res;
    int r;
    r  = rot % DW;
    kk = rot_left(64'(key_m), KB, rot % KB);
    k  = kk[DW-1:0];
    if (md) res = rot_left(64'(d), DW, (DW - r) % DW) ^ 64'(k);
    else    res = rot_left(64'(d ^ k), DW, r);
    return res[DW-1:0];
  endfunction

  // Output monitor: samples between edges; a transfer happens on the next
  // rising edge whenever reqOut and rdyOut are both high.
  always begin
    @(negedge clk);
    #2;
    if (reset && reqOut && rdyOut) begin
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("dataOut", 64'(dataOut), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DW-1:0] d, input int rot, input bit md);
    logic [63:0] rk;
    dataIn     = d;
    rot_offset = RW'(rot);
    mode       = md;
    prog       = 1'b0;
    rdyIn      = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (reqIn) begin
        exp_q.push_back(model_cipher(d, rot, md));
`ifdef ROTOR_ROLLING_KEY_EN
        rk    = rot_left(64'(key_m), KB, 1);
        key_m = rk[KB-1:0];
`else
        rk    = '0;
`endif
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("send_timeout_reqIn", 64'(reqIn), 64'd1);
  endtask

  task automatic idle_in();
    rdyIn = 1'b0;
    prog  = 1'b0;
    @(negedge clk);
  endtask

  task automatic prog_start();
    rdyIn     = 1'b0;
    prog      = 1'b1;
    key_cnt_m = 0;
    @(negedge clk);
  endtask

  task automatic prog_word(input logic [DW-1:0] w);
    dataIn = w;
    prog   = 1'b1;
    rdyIn  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (reqIn) begin
        key_m = KB'({key_m, w});
        if (key_cnt_m < KW) key_cnt_m++;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("prog_timeout_reqIn", 64'(reqIn), 64'd1);
  endtask

  task automatic prog_end();
    rdyIn = 1'b0;
    prog  = 1'b0;
    @(negedge clk);
    if (key_cnt_m < KW) key_m = '0;
  endtask

  task automatic program_key(input logic [DW-1:0] w);
    prog_start();
    for (int i = 0; i < KW; i++) prog_word(w + DW'(i));
    prog_end();
  endtask

  task automatic drain();
    rdyIn  = 1'b0;
    rdyOut = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    check("drain_reqOut", 64'(reqOut), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    longint t0;
    logic [DW-1:0] w5;
    reset      = 1'b1;
    dataIn     = '0;
    rot_offset = '0;
    mode       = 1'b0;
    prog       = 1'b0;
    rdyIn      = 1'b0;
    rdyOut     = 1'b0;
    key_m      = '0;
    key_cnt_m  = 0;
    rnd_on     = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_key", 64'(key), 64'd0);
    check("rst_reqIn", 64'(reqIn), 64'd0);
    check("rst_reqOut", 64'(reqOut), 64'd0);
    check("rst_dataOut", 64'(dataOut), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Programming: IDLE -> PROG -> RUN with key 0xCCE3.
    prog_start();
    #1;
    check("prog_state", 64'(state), 64'd1);
    check("prog_reqIn", 64'(reqIn), 64'd1);
    prog_word(16'hCCE3);
    prog_end();
    #1;
    check("run_state", 64'(state), 64'd2);
    check("run_key", 64'(key), 64'hCCE3);
    check("run_reqIn", 64'(reqIn), 64'd1);
    check("run_reqOut", 64'(reqOut), 64'd0);

    // Encrypt, then decrypt the ciphertext back.
    rdyOut = 1'b1;
    send_word(16'hF0F0, 7, 1'b0);
    #1;
    check("enc_reqOut", 64'(reqOut), 64'd1);
    check("enc_dataOut", 64'(dataOut), 64'h8B40);
    send_word(16'h8B40, 7, 1'b1);
    rdyIn = 1'b0;
    #1;
`ifndef ROTOR_ROLLING_KEY_EN
    check("dec_dataOut", 64'(dataOut), 64'hF0F0);
`endif
    drain();

    // Fill the FIFO with the sink stalled; the fifth word waits at the source.
    @(negedge clk);
    rdyOut = 1'b0;
    for (int i = 0; i < OD; i++) send_word(DW'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    w5     = DW'($urandom);
    dataIn = w5;
    rdyIn  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("full_reqIn", 64'(reqIn), 64'd0);
      check("full_reqOut", 64'(reqOut), 64'd1);
      @(negedge clk);
    end
    rdyOut = 1'b1;
    send_word(w5, 3, 1'b0);
    rdyIn = 1'b0;
    #1;
    check("pushpop_reqIn", 64'(reqIn), 64'd1);
    check("pushpop_reqOut", 64'(reqOut), 64'd1);
    drain();

    // Sustained throughput: one word per clock while the sink is ready.
    @(negedge clk);
    t0 = $time;
    for (int i = 0; i < 6; i++) send_word(DW'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    check("burst_cycles", 64'(($time - t0) / 10), 64'd6);
    drain();

    // Randomized traffic with a random sink, including a mid-stream re-key.
    @(negedge clk);
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(negedge clk);
          rdyOut = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      if (i == 20) program_key(DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle_in();
      send_word(DW'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    rdyIn  = 1'b0;
    rnd_on = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    drain();

    // Incomplete programming with data queued: key discarded, queue intact.
    @(negedge clk);
    rdyOut = 1'b0;
    send_word(DW'($urandom), 5, 1'b0);
    send_word(DW'($urandom), 9, 1'b1);
    prog_start();
    prog_end();
    #1;
    check("partial_state", 64'(state), 64'd0);
    check("partial_key", 64'(key), 64'(key_m));
    check("partial_reqIn", 64'(reqIn), 64'd0);
    check("partial_reqOut", 64'(reqOut), 64'd1);
    drain();

    // Reset with three words queued.
    @(negedge clk);
    program_key(DW'($urandom));
    rdyOut = 1'b0;
    for (int i = 0; i < 3; i++) send_word(DW'($urandom), int'($urandom_range(0, 15)), 1'b0);
    rdyIn = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("midrst_reqOut", 64'(reqOut), 64'd0);
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_reqIn", 64'(reqIn), 64'd0);
    check("midrst_key", 64'(key), 64'd0);
    exp_q.delete();
    key_m = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    program_key(DW'($urandom));
    send_word(DW'($urandom), 11, 1'b0);
    drain();

`ifdef ROTOR_ROLLING_KEY_EN
    // Rolling key: two encryptions of the same word see different keys.
    @(negedge clk);
    program_key(16'hCCE3);
    rdyOut = 1'b0;
    send_word(16'hF0F0, 0, 1'b0);
    send_word(16'hF0F0, 0, 1'b0);
    rdyIn = 1'b0;
    #1;
    check("roll_first", 64'(dataOut), 64'h3C13);
    rdyOut = 1'b1;
    @(negedge clk);
    #1;
    check("roll_second", 64'(dataOut), 64'h6937);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rotor_encrypter.md
Name: rotor_encrypter

Overview:
- Parametrised successor to the single-word XOR encrypter.
- Generalised data/key widths; multi-word key programming; encrypt and decrypt modes; output FIFO for back-pressure.
- Sits between the input word source and the transmit path, using the same reqIn/rdyIn and reqOut/rdyOut handshake pairs.
- One word per clock is sustained while the sink is ready.

Parameters:
DATA_WIDTH, 16, data word width in bits (>=8)
KEY_WORDS, 1, key length in data words; KEY_WIDTH = DATA_WIDTH*KEY_WORDS
ROT_WIDTH, 4, width of rot_offset
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (clk single clock domain)
dataIn  in  DATA_WIDTH  input word (data or key chunk)
rot_offset  in  ROT_WIDTH  rotation amount, sampled with each accepted data word
mode  in  1  0=encrypt, 1=decrypt, sampled per accepted word
prog  in  1  1 = accepted words are key chunks
rdyIn  in  1  source: dataIn valid
reqIn  out  1  block can accept a word
dataOut  out  DATA_WIDTH  FIFO head word
reqOut  out  1  dataOut valid (FIFO not empty)
rdyOut  in  1  sink accepts dataOut
key  out  KEY_WIDTH  current working key (debug)
state  out  2  0=IDLE, 1=PROG, 2=RUN

Behaviour:
- Reset (reset=0, async): key=0, state=IDLE, FIFO empty, key word counter=0, reqOut=0, dataOut=0, reqIn=0.
- Transfers:
  - Input transfer on a rising edge with reqIn&rdyIn.
  - Output transfer on a rising edge with reqOut&rdyOut.
- reqIn is decoded from registered state only:
  - PROG: 1.
  - RUN: !fifo_full.
  - IDLE: 0.
- State transitions:
  - IDLE/RUN -> PROG when prog=1. The counter clears on entry.
  - In PROG, each input transfer shifts dataIn into key from the LSB end: key = {key[KEY_WIDTH-DATA_WIDTH-1:0], dataIn}. Counter increments, saturating at KEY_WORDS.
  - PROG -> RUN on prog=0 if counter==KEY_WORDS.
  - PROG -> IDLE on prog=0 otherwise; key is cleared to 0 (partial key discarded).
  - Extra words past KEY_WORDS keep shifting; the last KEY_WORDS words win.
- Key words are never written to the FIFO. The FIFO keeps draining in any state.
- Data path (RUN), per accepted word:
  - r = rot_offset mod DATA_WIDTH.
  - k = low DATA_WIDTH bits of rotl(key, rot_offset mod KEY_WIDTH).
  - Encrypt: out = rotl(dataIn ^ k, r).
  - Decrypt: out = rotr(dataIn, r) ^ k.
- Latency: a word accepted at edge N is visible on dataOut with reqOut=1 after edge N if the FIFO was empty. Words are delivered in order.
- FIFO full: reqIn=0, so no input transfer is possible.
- Push and pop on the same edge: occupancy unchanged, both succeed.
- Pop from the last entry: reqOut drops after that edge unless a push coincides.
- dataOut holds its value while reqOut=1 and rdyOut=0. When the FIFO is empty, dataOut holds the last popped value.
- prog asserted while data sits in the FIFO: queued words are unaffected and drain normally.
- Reset mid-operation: all queued words are lost; the key must be re-programmed.

Optional Feature:
- Macro: ROTOR_ROLLING_KEY_EN.
- Defined: after every accepted data word in RUN, key <= rotl(key,1). Programming replaces the key.
- Undefined: key is static between programming sessions.

Test Plan:
- Reset, then prog=1 with dataIn=0xCCE3, then prog=0 (DATA_WIDTH=16, KEY_WORDS=1) -> state PROG then RUN; key=0xCCE3; reqIn=1; reqOut=0.
- Encrypt dataIn=0xF0F0, rot_offset=7, rdyOut=1 -> dataOut=0x8B40, reqOut=1 one edge later.
- Decrypt with same key: dataIn=0x8B40, rot_offset=7, mode=1 -> dataOut=0xF0F0.
- rdyOut=0 and push 5 words (OUT_DEPTH=4) -> reqIn=0 after the 4th; the 5th is held at source; raise rdyOut -> 4 words out in order, then the 5th; simultaneous push/pop keeps occupancy.
- KEY_WORDS=2: prog one word then prog=0 -> state IDLE, key=0, reqIn=0. Reset asserted mid-stream with 3 words queued -> reqOut=0 immediately, state IDLE.
- ROTOR_ROLLING_KEY_EN defined, key 0xCCE3, encrypt 0xF0F0 twice, rot_offset=0 -> outputs 0x3C13, then 0x6937 (key 0x99C7).
